// File: rtl/board_upload_pkg.sv
// Shared types and constants for the Avalon-MM board/palette uploader.
package board_upload_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        PAL,
        FETCH,
        CAPTURE,
        WRITE,
        DONE
    } state_t;

    localparam int unsigned DEF_NUM_CELLS = 200;
    localparam int unsigned DEF_PAL_BASE  = 201;
    localparam int unsigned DEF_NUM_PAL   = 16;

    localparam int unsigned PAL_W      = 12;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CELL_IDX_W = 8;
    localparam int unsigned PAL_IDX_W  = 4;

    localparam logic [3:0] BYTE_EN_ALL = 4'b1111;

endpackage

// File: rtl/vs_edge_detect.sv
// Registered falling-edge detector for the active-low VGA vertical sync.
module vs_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic vs,
    output logic fall
);

    logic vs_prev;

    // vs_prev resets low so a sync already low at reset is not taken as an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_prev <= 1'b0;
            fall    <= 1'b0;
        end else begin
            vs_prev <= vs;
            fall    <= vs_prev & ~vs;
        end
    end

endmodule

// File: rtl/avl_board_uploader.sv
// Avalon-MM master copying an optional palette and the board cells into the
// display slave, one word write per entry, optionally aligned to vertical blank.
module avl_board_uploader
    import board_upload_pkg::*;
#(
    parameter int unsigned NUM_CELLS   = DEF_NUM_CELLS,
    parameter int unsigned PAL_BASE    = DEF_PAL_BASE,
    parameter int unsigned NUM_PAL     = DEF_NUM_PAL,
    parameter bit          WAIT_VBLANK = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     start,
    input  logic                     pal_en,
    input  logic [NUM_PAL*PAL_W-1:0] pal_in,
    input  logic                     vs,
    output logic [CELL_IDX_W-1:0]    src_addr,
    input  logic [3:0]               src_data,
    output logic [ADDR_W-1:0]        avm_address,
    output logic                     avm_write,
    output logic [DATA_W-1:0]        avm_writedata,
    output logic [3:0]               avm_byteenable,
    input  logic                     avm_waitrequest,
    output logic                     busy,
    output logic                     done
);

    localparam logic [CELL_IDX_W-1:0] LAST_CELL = CELL_IDX_W'(NUM_CELLS - 1);
    localparam logic [PAL_IDX_W-1:0]  LAST_PAL  = PAL_IDX_W'(NUM_PAL - 1);

    state_t                 state_q, state_d;
    logic                   pal_en_q, pal_en_d;
    logic                   pending_q, pending_d;
    logic [PAL_IDX_W-1:0]   pal_idx_q, pal_idx_d;
    logic [CELL_IDX_W-1:0]  cell_idx_q, cell_idx_d;
    logic [CELL_IDX_W-1:0]  src_addr_d;
    logic [ADDR_W-1:0]      address_d;
    logic                   write_d;
    logic [DATA_W-1:0]      wdata_d;
    logic [3:0]             be_d;
    logic                   busy_d, done_d;
    logic                   vs_fall;
    logic                   begin_pass, launch, launch_pal, load_pal, go_fetch;
    logic [PAL_W-1:0]       pal_tab [NUM_PAL];

    vs_edge_detect u_vs_edge (
        .clk   (CLK),
        .reset (RESET),
        .vs    (vs),
        .fall  (vs_fall)
    );

    for (genvar g = 0; g < NUM_PAL; g++) begin : g_pal
        assign pal_tab[g] = pal_in[g*PAL_W +: PAL_W];
    end

    // Next state and next registered outputs; outputs hold unless a step changes them
    always_comb begin
        state_d    = state_q;
        pal_en_d   = pal_en_q;
        pending_d  = pending_q;
        pal_idx_d  = pal_idx_q;
        cell_idx_d = cell_idx_q;
        src_addr_d = src_addr;
        address_d  = avm_address;
        write_d    = avm_write;
        wdata_d    = avm_writedata;
        busy_d     = busy;
        done_d     = 1'b0;
        begin_pass = 1'b0;
        launch     = 1'b0;
        launch_pal = pal_en_q;
        load_pal   = 1'b0;
        go_fetch   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pal_en_d   = pal_en;
                    busy_d     = 1'b1;
                    begin_pass = 1'b1;
                end
            end
            VSYNC: begin
                if (vs_fall) begin
                    launch = 1'b1;
                end
            end
            PAL: begin
                if (!avm_waitrequest) begin
                    if (pal_idx_q == LAST_PAL) begin
                        go_fetch = 1'b1;
                    end else begin
                        pal_idx_d = pal_idx_q + 1'b1;
                        load_pal  = 1'b1;
                    end
                end
            end
            FETCH: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                wdata_d   = DATA_W'(src_data);
                address_d = ADDR_W'(cell_idx_q);
                write_d   = 1'b1;
                state_d   = WRITE;
            end
            WRITE: begin
                if (!avm_waitrequest) begin
                    write_d = 1'b0;
                    if (cell_idx_q == LAST_CELL) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        cell_idx_d = cell_idx_q + 1'b1;
                        go_fetch   = 1'b1;
                    end
                end
            end
            DONE: begin
                // a start landing on DONE chains straight into the next pass
                if (pending_q || start) begin
                    pending_d  = 1'b0;
                    begin_pass = 1'b1;
                    if (start) begin
                        pal_en_d = pal_en;
                    end
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start && state_q != IDLE && state_q != DONE) begin
            pending_d = 1'b1;
            pal_en_d  = pal_en;
        end

        if (begin_pass) begin
            pal_idx_d  = '0;
            cell_idx_d = '0;
            launch_pal = pal_en_d;
            if (WAIT_VBLANK) begin
                state_d = VSYNC;
                write_d = 1'b0;
            end else begin
                launch = 1'b1;
            end
        end

        if (launch) begin
            if (launch_pal) begin
                load_pal = 1'b1;
            end else begin
                go_fetch = 1'b1;
            end
        end

        if (load_pal) begin
            state_d   = PAL;
            write_d   = 1'b1;
            address_d = ADDR_W'(PAL_BASE) + ADDR_W'(pal_idx_d);
            wdata_d   = DATA_W'(pal_tab[pal_idx_d]);
        end

        if (go_fetch) begin
            state_d    = FETCH;
            write_d    = 1'b0;
            src_addr_d = cell_idx_d;
        end

        be_d = write_d ? BYTE_EN_ALL : 4'b0000;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= IDLE;
            pal_en_q       <= 1'b0;
            pending_q      <= 1'b0;
            pal_idx_q      <= '0;
            cell_idx_q     <= '0;
            src_addr       <= '0;
            avm_address    <= '0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            pal_en_q       <= pal_en_d;
            pending_q      <= pending_d;
            pal_idx_q      <= pal_idx_d;
            cell_idx_q     <= cell_idx_d;
            src_addr       <= src_addr_d;
            avm_address    <= address_d;
            avm_write      <= write_d;
            avm_writedata  <= wdata_d;
            avm_byteenable <= be_d;
            busy           <= busy_d;
            done           <= done_d;
        end
    end

endmodule

// File: tb/tb_avl_board_uploader.sv
// Directed self-checking bench: write-sequence model plus literal timing pins.
`timescale 1ns/1ps
module tb_avl_board_uploader;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic         RESET, vs;
    logic         start0, pal_en0, start1, pal_en1, wreq0, wreq1;
    logic [191:0] pal_in;
    logic [7:0]   src_addr0, src_addr1;
    logic [3:0]   src_data0, src_data1;
    logic [11:0]  addr0, addr1;
    logic         write0, write1;
    logic [31:0]  wdata0, wdata1;
    logic [3:0]   be0, be1;
    logic         busy0, busy1, done0, done1;
    logic [3:0]   mem [0:255];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int t0 = 0;

    wr_t         exp_q[$];
    int          writes_seen, pal_hits, stall_cycles, stalled_for, stall_left;
    bit          stall_en, wreq_force, prev_stall;
    logic [11:0] prev_addr;
    logic [31:0] prev_data;
    logic [3:0]  prev_be;
    logic [11:0] log_addr [0:511];
    logic [31:0] log_data [0:511];

    avl_board_uploader #(.WAIT_VBLANK(1'b0)) dut0 (
        .CLK(CLK), .RESET(RESET), .start(start0), .pal_en(pal_en0), .pal_in(pal_in),
        .vs(vs), .src_addr(src_addr0), .src_data(src_data0), .avm_address(addr0),
        .avm_write(write0), .avm_writedata(wdata0), .avm_byteenable(be0),
        .avm_waitrequest(wreq0), .busy(busy0), .done(done0)
    );

    avl_board_uploader #(.WAIT_VBLANK(1'b1)) dut1 (
        .CLK(CLK), .RESET(RESET), .start(start1), .pal_en(pal_en1), .pal_in(pal_in),
        .vs(vs), .src_addr(src_addr1), .src_data(src_data1), .avm_address(addr1),
        .avm_write(write1), .avm_writedata(wdata1), .avm_byteenable(be1),
        .avm_waitrequest(wreq1), .busy(busy1), .done(done1)
    );

    // Board buffer: one-cycle read latency
    always @(posedge CLK) begin
        src_data0 <= mem[src_addr0];
        src_data1 <= mem[src_addr1];
        cyc       <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] pal_word(input int i);
        logic [191:0] p;
        p = pal_in;
        return p[12*i +: 12];
    endfunction

    // A pass is: palette entries (if enabled) then every board cell, in order
    task automatic model_pass(input bit pal);
        if (pal) begin
            for (int i = 0; i < 16; i++) exp_q.push_back('{addr: 12'(201 + i), data: 32'(pal_word(i))});
        end
        for (int i = 0; i < 200; i++) exp_q.push_back('{addr: 12'(i), data: 32'(mem[i])});
    endtask

    task automatic clear_stats();
        writes_seen  = 0;
        pal_hits     = 0;
        stall_cycles = 0;
        stalled_for  = -1;
    endtask

    task automatic go0(input bit pal);
        clear_stats();
        model_pass(pal);
        start0  = 1'b1;
        pal_en0 = pal;
        t0      = cyc;
        @(negedge CLK);
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge CLK);
            if (done0) begin
                at = cyc - t0;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL done0_timeout: no done within %0d cycles", budget);
        end
    endtask

    // Waitrequest generation and write-stream comparison for dut0
    always @(negedge CLK) begin
        if (RESET) begin
            wreq0      = 1'b0;
            prev_stall = 1'b0;
            stall_left = 0;
        end else begin
            if (stall_left > 0) begin
                wreq0 = 1'b1;
                stall_left--;
            end else if (stall_en && write0 && (writes_seen % 5 == 4) && stalled_for != writes_seen) begin
                wreq0       = 1'b1;
                stall_left  = 1;
                stalled_for = writes_seen;
            end else begin
                wreq0 = 1'b0;
            end
            if (wreq_force) wreq0 = 1'b1;

            if (prev_stall) begin
                checks++;
                if (!write0 || addr0 !== prev_addr || wdata0 !== prev_data || be0 !== prev_be) begin
                    failures++;
                    $display("FAIL stall_hold: got w=%0b a=%0h d=%0h be=%0h expected w=1 a=%0h d=%0h be=%0h",
                             write0, addr0, wdata0, be0, prev_addr, prev_data, prev_be);
                end
            end

            if (write0) begin
                if (wreq0) begin
                    stall_cycles++;
                end else begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL extra_write: got a=%0h d=%0h expected no write", addr0, wdata0);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        if (addr0 !== e.addr || wdata0 !== e.data || be0 !== 4'hF) begin
                            failures++;
                            $display("FAIL write%0d: got a=%0h d=%0h be=%0h expected a=%0h d=%0h be=f",
                                     writes_seen, addr0, wdata0, be0, e.addr, e.data);
                        end
                    end
                    if (addr0 >= 12'd201) pal_hits++;
                    if (writes_seen < 512) begin
                        log_addr[writes_seen] = addr0;
                        log_data[writes_seen] = wdata0;
                    end
                    writes_seen++;
                end
                prev_stall = wreq0;
                prev_addr  = addr0;
                prev_data  = wdata0;
                prev_be    = be0;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        int at, c, n, busy_low, dcnt;
        RESET = 1'b1; vs = 1'b1; wreq1 = 1'b0;
        start0 = 1'b0; pal_en0 = 1'b0; start1 = 1'b0; pal_en1 = 1'b0;
        stall_en = 1'b0; wreq_force = 1'b0;
        for (int i = 0; i < 16; i++) pal_in[12*i +: 12] = {4'(i), 4'(15 - i), 4'(i ^ 5)};
        pal_in[47:36] = 12'hF0A;
        for (int i = 0; i < 256; i++) mem[i] = 4'((i * 7 + 3) % 16);
        mem[57] = 4'h6;
        clear_stats();

        repeat (3) @(negedge CLK);
        check("rst_write", write0, 0);
        check("rst_addr", addr0, 0);
        check("rst_data", wdata0, 0);
        check("rst_be", be0, 0);
        check("rst_src_addr", src_addr0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // Zero-wait pass with palette
        go0(1'b1);
        check("t1_busy_c1", busy0, 1);
        check("t1_addr_c1", addr0, 201);
        check("t1_data_c1", wdata0, 32'h0000_00F5);
        wait_done0(700, at);
        check("t1_done_cycle", at, 617);
        check("t1_writes", writes_seen, 216);
        check("t1_pal3_addr", log_addr[3], 204);
        check("t1_pal3_data", log_data[3], 32'h0000_0F0A);
        check("t1_cell57_addr", log_addr[73], 57);
        check("t1_cell57_data", log_data[73], 32'h0000_0006);
        @(negedge CLK);
        check("t1_done_width", done0, 0);
        check("t1_busy_end", busy0, 0);

        // No palette, 2-cycle stall on every 5th write
        stall_en = 1'b1;
        go0(1'b0);
        wait_done0(800, at);
        stall_en = 1'b0;
        check("t2_done_cycle", at, 681);
        check("t2_writes", writes_seen, 200);
        check("t2_pal_hits", pal_hits, 0);
        check("t2_stall_cycles", stall_cycles, 80);
        check("t2_first_addr", log_addr[0], 0);
        check("t2_last_addr", log_addr[199], 199);
        check("t2_cell57_data", log_data[57], 32'h6);
        @(negedge CLK);

        // Three starts during a pass coalesce into one extra pass; last pal_en=0 wins
        go0(1'b1);
        model_pass(1'b0);
        busy_low = 0; dcnt = 0; at = -1;
        while (dcnt < 2 && cyc - t0 < 1400) begin
            c = cyc - t0;
            start0  = (c == 50 || c == 100 || c == 150);
            pal_en0 = (c != 150);
            if (!busy0) busy_low++;
            if (done0) begin
                dcnt++;
                at = c;
            end
            if (dcnt < 2) @(negedge CLK);
        end
        start0 = 1'b0;
        check("t3_done_count", dcnt, 2);
        check("t3_done2_cycle", at, 1218);
        check("t3_busy_gap", busy_low, 0);
        check("t3_writes", writes_seen, 416);
        n = 0;
        repeat (40) begin
            @(negedge CLK);
            if (done0) n++;
        end
        check("t3_no_third_pass", n, 0);
        check("t3_busy_idle", busy0, 0);
        check("t3_queue_empty", exp_q.size(), 0);

        // Reset while cell 100 is stalled in WRITE
        go0(1'b1);
        n = 0;
        while (src_addr0 != 8'd100 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        wreq_force = 1'b1;
        while (!(write0 && addr0 == 12'd100) && n < 410) begin
            @(negedge CLK);
            n++;
        end
        check("t4_reached_cell100", (n < 410), 1);
        repeat (2) @(negedge CLK);
        check("t4_stalled_write", write0, 1);
        RESET = 1'b1;
        @(negedge CLK);
        check("t4_rst_write", write0, 0);
        check("t4_rst_busy", busy0, 0);
        exp_q.delete();
        wreq_force = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        go0(1'b1);
        check("t4_restart_addr", addr0, 201);
        wait_done0(700, at);
        check("t4_done_cycle", at, 617);
        check("t4_writes", writes_seen, 216);
        check("t4_first_log", log_addr[0], 201);
        @(negedge CLK);

        // Start in the DONE cycle chains the next pass with no idle gap
        go0(1'b0);
        model_pass(1'b1);
        wait_done0(700, at);
        check("t5_done1_cycle", at, 601);
        start0  = 1'b1;
        pal_en0 = 1'b1;
        t0      = cyc;
        @(negedge CLK);
        start0 = 1'b0;
        check("t5_busy_kept", busy0, 1);
        check("t5_write_now", write0, 1);
        check("t5_addr_now", addr0, 201);
        wait_done0(700, at);
        check("t5_done2_cycle", at, 617);
        check("t5_writes", writes_seen, 416);
        @(negedge CLK);
        check("t5_busy_end", busy0, 0);

        // Vertical-blank deferral on dut1
        start1  = 1'b1;
        pal_en1 = 1'b1;
        t0      = cyc;
        @(negedge CLK);
        start1 = 1'b0;
        check("t6_busy_c1", busy1, 1);
        n = 0;
        for (int k = 1; k < 42; k++) begin
            if (write1) n++;
            if (k == 40) vs = 1'b0;
            @(negedge CLK);
        end
        check("t6_no_early_write", n, 0);
        check("t6_first_write", write1, 1);
        check("t6_first_addr", addr1, 201);
        check("t6_first_data", wdata1, 32'h0000_00F5);
        check("t6_first_be", be1, 4'hF);
        at = -1;
        for (int k = 0; k < 800; k++) begin
            if (done1) begin
                at = cyc - t0;
                break;
            end
            @(negedge CLK);
        end
        vs = 1'b1;
        check("t6_done_cycle", at, 658);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
